// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//   Memory-access stage of the power-optimized RISC-V pipeline. Registers the
//   execute result, runs byte/half/word loads and stores over a req/ack data
//   memory port and emits a single-cycle write-back pulse. Non-memory ops
//   pass straight through with one cycle of latency. Misaligned or illegal
//   accesses and memory timeouts are reported as one-cycle error pulses.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   enable            stage enable (low blocks new accepts only)
//   ex_*              execute-stage handshake and instruction fields
//   ex_ready          IDLE && enable (combinational)
//   mem_*             data-memory request port (held until ack or abort)
//   wb_*              write-back pulse, register index, data, write enable
//   misalign_err      pulse: misaligned access or illegal funct3
//   bus_err           pulse: memory did not ack within TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [6:0]  ex_opcode,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  // Counter value seen on the edge that ends the TIMEOUT_CYCLES-th wait cycle.
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  state_t      state, state_next;
  logic [7:0]  tmo_cnt;
  logic [4:0]  lat_rd;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;

  logic        accept, is_load, is_store, is_mem;
  logic        f3_legal, aligned, mem_go, mem_bad, rd_writer;
  logic        ack_hit, tmo_hit;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign ex_ready = (state == IDLE) && enable;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (mem_go) state_next = MEM_WAIT;
      MEM_WAIT: if (ack_hit || tmo_hit) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Decode of the incoming instruction and of the current memory handshake.
  always_comb begin
    accept   = ex_valid && ex_ready;
    is_load  = (ex_opcode == OPC_LOAD);
    is_store = (ex_opcode == OPC_STORE);
    is_mem   = is_load || is_store;

    f3_legal = 1'b0;
    if (is_load)       f3_legal = ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else if (is_store) f3_legal = (ex_funct3 <= 3'b010);

    // funct3[1:0] encodes access size for both loads and stores.
    case (ex_funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = !ex_result[0];
      2'b10:   aligned = (ex_result[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase

    mem_go  = accept && is_mem && f3_legal && aligned;
    mem_bad = accept && is_mem && !(f3_legal && aligned);

    case (ex_opcode)
      7'b0110011, 7'b0010011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100111: rd_writer = 1'b1;
      default:                            rd_writer = 1'b0;
    endcase

    ack_hit = (state == MEM_WAIT) && mem_req && mem_ack;
    // Ack on the expiry edge takes priority, hence the !mem_ack term.
    tmo_hit = (state == MEM_WAIT) && !mem_ack && (tmo_cnt == TMO_LAST);
  end

  // Store lanes are replicated so the memory only has to honour the strobes.
  always_comb begin
    case (ex_funct3[1:0])
      2'b00: begin
        st_wstrb = 4'b0001 << ex_result[1:0];
        st_wdata = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        st_wstrb = 4'b0011 << ex_result[1:0];
        st_wdata = {2{ex_store_data[15:0]}};
      end
      default: begin
        st_wstrb = 4'b1111;
        st_wdata = ex_store_data;
      end
    endcase
  end

  // Load extraction works on the live mem_rdata, which is captured into
  // wb_data on the ack edge.
  always_comb begin
    case (lat_off)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt      <= '0;
      lat_rd       <= '0;
      lat_funct3   <= '0;
      lat_off      <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;

      if (accept) begin
        lat_rd     <= ex_rd;
        lat_funct3 <= ex_funct3;
        lat_off    <= ex_result[1:0];
        if (!is_mem) begin
          wb_valid <= 1'b1;
          wb_we    <= rd_writer && (ex_rd != 5'd0);
          wb_rd    <= ex_rd;
          wb_data  <= ex_result;
        end else if (mem_bad) begin
          wb_valid     <= 1'b1;
          wb_we        <= 1'b0;
          wb_rd        <= ex_rd;
          wb_data      <= ex_result;
          misalign_err <= 1'b1;
        end else begin
          mem_req   <= 1'b1;
          mem_we    <= is_store;
          mem_addr  <= {ex_result[31:2], 2'b00};
          mem_wdata <= is_store ? st_wdata : 32'd0;
          mem_wstrb <= is_store ? st_wstrb : 4'd0;
          tmo_cnt   <= '0;
        end
      end

      if (ack_hit) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_wstrb <= '0;
        wb_valid  <= 1'b1;
        wb_rd     <= lat_rd;
        if (mem_we) begin
          wb_we <= 1'b0;
        end else begin
          wb_we   <= (lat_rd != 5'd0);
          wb_data <= ld_data;
        end
      end else if (tmo_hit) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_wstrb <= '0;
        wb_valid  <= 1'b1;
        wb_we     <= 1'b0;
        wb_rd     <= lat_rd;
        bus_err   <= 1'b1;
      end else if (state == MEM_WAIT) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam logic [31:0] OP_IMM = 32'h13;
  localparam logic [31:0] OP_REG = 32'h33;
  localparam logic [31:0] LOAD   = 32'h03;
  localparam logic [31:0] STORE  = 32'h23;
  localparam logic [31:0] LUI    = 32'h37;
  localparam logic [31:0] BRANCH = 32'h63;

  logic        clk = 1'b0;
  logic        reset, enable, ex_valid, ex_ready;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result, ex_store_data;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_valid, wb_we, misalign_err, bus_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] opcode;
    logic [31:0] funct3;
    logic [31:0] rd;
    logic [31:0] result;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          ack_delay;
    logic [31:0] exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_mwe;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wstrb;
    logic [31:0] exp_wb_we;
    logic [31:0] exp_wb_data;
    logic [31:0] exp_mis;
    logic [31:0] chk_data;
  } vec_t;

  vec_t vecs[19];

  mem_access_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_rd(ex_rd),
    .ex_result(ex_result), .ex_store_data(ex_store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic driveOp(input logic [31:0] opc, input logic [31:0] f3,
                         input logic [31:0] rd, input logic [31:0] res,
                         input logic [31:0] sd);
    ex_valid      = 1'b1;
    ex_opcode     = opc[6:0];
    ex_funct3     = f3[2:0];
    ex_rd         = rd[4:0];
    ex_result     = res;
    ex_store_data = sd;
  endtask

  // One instruction: accept, optional memory handshake, write-back check.
  task automatic applyStimulus(input vec_t v, input int idx);
    int held;
    @(negedge clk);
    driveOp(v.opcode, v.funct3, v.rd, v.result, v.sdata);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    checkOutput($sformatf("v%0d mem_req", idx), 32'(mem_req), v.exp_req);
    if (v.exp_req != 0) begin
      checkOutput($sformatf("v%0d mem_addr", idx), mem_addr, v.exp_addr);
      checkOutput($sformatf("v%0d mem_we", idx), 32'(mem_we), v.exp_mwe);
      checkOutput($sformatf("v%0d mem_wstrb", idx), 32'(mem_wstrb), v.exp_wstrb);
      if (v.exp_mwe != 0)
        checkOutput($sformatf("v%0d mem_wdata", idx), mem_wdata, v.exp_wdata);
      checkOutput($sformatf("v%0d ex_ready_wait", idx), 32'(ex_ready), 32'd0);
      checkOutput($sformatf("v%0d wb_valid_wait", idx), 32'(wb_valid), 32'd0);
      held = 0;
      for (int c = 1; c <= v.ack_delay; c++) begin
        if (mem_req) held++;
        if (c == v.ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
        end
        @(posedge clk); #1;
      end
      mem_ack   = 1'b0;
      mem_rdata = 32'd0;
      checkOutput($sformatf("v%0d req_cycles", idx), 32'(held), 32'(v.ack_delay));
    end
    checkOutput($sformatf("v%0d wb_valid", idx), 32'(wb_valid), 32'd1);
    checkOutput($sformatf("v%0d wb_we", idx), 32'(wb_we), v.exp_wb_we);
    checkOutput($sformatf("v%0d wb_rd", idx), 32'(wb_rd), v.rd);
    checkOutput($sformatf("v%0d misalign_err", idx), 32'(misalign_err), v.exp_mis);
    checkOutput($sformatf("v%0d bus_err", idx), 32'(bus_err), 32'd0);
    checkOutput($sformatf("v%0d mem_req_after", idx), 32'(mem_req), 32'd0);
    checkOutput($sformatf("v%0d ex_ready_after", idx), 32'(ex_ready), 32'd1);
    if (v.chk_data != 0)
      checkOutput($sformatf("v%0d wb_data", idx), wb_data, v.exp_wb_data);
  endtask

  initial begin
    int held;
    //              opc     f3 rd  result        sdata         rdata         dly req addr        mwe wdata         strb  wbwe wbdata        mis chk
    vecs[0]  = '{OP_IMM, 0, 5,  32'h0000_00AB, 0,            0,            0,  0, 0,           0, 0,            0,    1, 32'h0000_00AB, 0, 1};
    vecs[1]  = '{LOAD,   2, 6,  32'h0000_0100, 0,            32'hDEADBEEF, 3,  1, 32'h100,     0, 0,            0,    1, 32'hDEADBEEF,  0, 1};
    vecs[2]  = '{LOAD,   0, 7,  32'h0000_0103, 0,            32'h80FF_0000, 1, 1, 32'h100,     0, 0,            0,    1, 32'hFFFF_FF80, 0, 1};
    vecs[3]  = '{LOAD,   4, 7,  32'h0000_0103, 0,            32'h80FF_0000, 2, 1, 32'h100,     0, 0,            0,    1, 32'h0000_0080, 0, 1};
    vecs[4]  = '{LOAD,   1, 8,  32'h0000_0102, 0,            32'h80FF_0000, 1, 1, 32'h100,     0, 0,            0,    1, 32'hFFFF_80FF, 0, 1};
    vecs[5]  = '{LOAD,   5, 8,  32'h0000_0102, 0,            32'h80FF_0000, 1, 1, 32'h100,     0, 0,            0,    1, 32'h0000_80FF, 0, 1};
    vecs[6]  = '{STORE,  1, 0,  32'h0000_0206, 32'h1234_5678, 0,           2,  1, 32'h204,     1, 32'h5678_5678, 32'hC, 0, 0,           0, 0};
    vecs[7]  = '{STORE,  0, 0,  32'h0000_0101, 32'h0000_00A5, 0,           1,  1, 32'h100,     1, 32'hA5A5_A5A5, 32'h2, 0, 0,           0, 0};
    vecs[8]  = '{STORE,  2, 0,  32'h0000_0300, 32'hCAFE_F00D, 0,           1,  1, 32'h300,     1, 32'hCAFE_F00D, 32'hF, 0, 0,           0, 0};
    vecs[9]  = '{LOAD,   2, 9,  32'h0000_0102, 0,            0,            0,  0, 0,           0, 0,            0,    0, 0,             1, 0};
    vecs[10] = '{LOAD,   1, 9,  32'h0000_0101, 0,            0,            0,  0, 0,           0, 0,            0,    0, 0,             1, 0};
    vecs[11] = '{LOAD,   3, 9,  32'h0000_0100, 0,            0,            0,  0, 0,           0, 0,            0,    0, 0,             1, 0};
    vecs[12] = '{STORE,  3, 0,  32'h0000_0100, 32'h1,        0,            0,  0, 0,           0, 0,            0,    0, 0,             1, 0};
    vecs[13] = '{OP_REG, 0, 0,  32'h0000_0005, 0,            0,            0,  0, 0,           0, 0,            0,    0, 32'h0000_0005, 0, 1};
    vecs[14] = '{BRANCH, 0, 3,  32'h0000_0077, 0,            0,            0,  0, 0,           0, 0,            0,    0, 32'h0000_0077, 0, 1};
    vecs[15] = '{LUI,    0, 1,  32'h1234_5000, 0,            0,            0,  0, 0,           0, 0,            0,    1, 32'h1234_5000, 0, 1};
    vecs[16] = '{LOAD,   2, 0,  32'h0000_0104, 0,            32'h1122_3344, 1, 1, 32'h104,     0, 0,            0,    0, 32'h1122_3344, 0, 1};
    vecs[17] = '{LOAD,   0, 10, 32'h0000_0201, 0,            32'h0000_7F00, 1, 1, 32'h200,     0, 0,            0,    1, 32'h0000_007F, 0, 1};
    vecs[18] = '{LOAD,   2, 4,  32'h0000_0500, 0,            32'h0BAD_CAFE, 16, 1, 32'h500,    0, 0,            0,    1, 32'h0BAD_CAFE, 0, 1};

    reset = 1'b0; enable = 1'b0; ex_valid = 1'b0;
    ex_opcode = '0; ex_funct3 = '0; ex_rd = '0; ex_result = '0; ex_store_data = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    // Reset state
    #12;
    checkOutput("rst mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst mem_addr", mem_addr, 32'd0);
    checkOutput("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
    checkOutput("rst wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst wb_data", wb_data, 32'd0);
    checkOutput("rst wb_rd", 32'(wb_rd), 32'd0);
    checkOutput("rst errs", 32'({misalign_err, bus_err}), 32'd0);
    checkOutput("rst ex_ready", 32'(ex_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1; enable = 1'b1;
    #1 checkOutput("ex_ready after reset", 32'(ex_ready), 32'd1);

    for (int i = 0; i < 19; i++) applyStimulus(vecs[i], i);

    // Back-to-back non-memory accepts
    @(negedge clk);
    driveOp(OP_IMM, 0, 2, 32'h1, 0);
    @(posedge clk); #1;
    checkOutput("b2b first wb_data", wb_data, 32'h1);
    checkOutput("b2b ex_ready", 32'(ex_ready), 32'd1);
    driveOp(OP_IMM, 0, 3, 32'h2, 0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    checkOutput("b2b second wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("b2b second wb_data", wb_data, 32'h2);
    checkOutput("b2b second wb_rd", 32'(wb_rd), 32'd3);
    @(posedge clk); #1;
    checkOutput("b2b pulse ends", 32'(wb_valid), 32'd0);
    checkOutput("b2b wb_data holds", wb_data, 32'h2);

    // Store timeout
    @(negedge clk);
    driveOp(STORE, 2, 0, 32'h400, 32'h55);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    held = 0;
    while (mem_req && held < 40) begin
      held++;
      @(posedge clk); #1;
    end
    checkOutput("tmo req_cycles", 32'(held), 32'd16);
    checkOutput("tmo bus_err", 32'(bus_err), 32'd1);
    checkOutput("tmo wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("tmo wb_we", 32'(wb_we), 32'd0);
    checkOutput("tmo mem_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    checkOutput("tmo bus_err clears", 32'(bus_err), 32'd0);

    // enable low: no accept
    @(negedge clk);
    enable = 1'b0;
    driveOp(OP_IMM, 0, 5, 32'h99, 0);
    #1 checkOutput("en0 ex_ready", 32'(ex_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput("en0 no wb_valid", 32'(wb_valid), 32'd0);
    @(negedge clk);
    ex_valid = 1'b0; enable = 1'b1;

    // enable dropped during MEM_WAIT: ack still completes
    @(negedge clk);
    driveOp(LOAD, 2, 11, 32'h600, 0);
    @(posedge clk); #1;
    ex_valid = 1'b0; enable = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_0F0F;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checkOutput("en0 wait wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("en0 wait wb_data", wb_data, 32'hA5A5_0F0F);
    enable = 1'b1;

    // Async reset two cycles into MEM_WAIT
    @(negedge clk);
    driveOp(LOAD, 2, 12, 32'h700, 0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(posedge clk); #3;
    checkOutput("arst req before", 32'(mem_req), 32'd1);
    reset = 1'b0;
    #1 checkOutput("arst req drops", 32'(mem_req), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checkOutput("arst no wb_valid", 32'(wb_valid), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checkOutput("stray ack ignored", 32'(wb_valid), 32'd0);
    applyStimulus(vecs[0], 100);
    applyStimulus(vecs[1], 101);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
